// File: rtl/frame_buffer_writer.sv
// Camera-to-frame-buffer writer: turns a valid-qualified pixel stream into
// row-major write transactions with frame_done and sticky overflow flags.
module frame_buffer_writer #(
    parameter int H_PIXELS = 320,
    parameter int V_PIXELS = 240
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    input  logic        pixel_valid_in,
    input  logic [15:0] pixel_data_in,
    output logic [16:0] pixel_addr_out,
    output logic [15:0] pixel_data_out,
    output logic        we_out,
    output logic        frame_done_out,
    output logic        error_out
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [16:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [16:0]   y_ext;
    logic [16:0]   row_base;
    logic          accept;
    logic          last_x;
    logic          last_pixel;

    // A coincident frame_start makes this pixel the first of the new frame.
    assign cur_x      = frame_start_in ? '0 : x_q;
    assign cur_y      = frame_start_in ? '0 : y_q;
    assign accept     = pixel_valid_in && (frame_start_in || state_q == CAPTURE);
    assign last_x     = (cur_x == XW'(H_PIXELS - 1));
    assign last_pixel = last_x && (cur_y == YW'(V_PIXELS - 1));
    assign y_ext      = 17'(cur_y);

    generate
        if (H_PIXELS == 320) begin : g_shift
            assign row_base = (y_ext << 8) + (y_ext << 6);
        end else begin : g_mul
            assign row_base = y_ext * 17'(H_PIXELS);
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (frame_start_in) begin
            state_d = CAPTURE;
            x_d     = '0;
            y_d     = '0;
        end
        if (accept) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_pixel ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
                y_d = cur_y;
            end
            if (last_pixel) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        we_d   = accept;
        done_d = accept && last_pixel;
        addr_d = addr_q;
        data_d = data_q;
        err_d  = err_q;
        if (accept) begin
            addr_d = row_base + 17'(cur_x);
            data_d = pixel_data_in;
        end
        if (frame_start_in) begin
            err_d = 1'b0;
        end else if (pixel_valid_in && state_q == IDLE) begin
            err_d = 1'b1;
        end
    end

    assign pixel_addr_out = addr_q;
    assign pixel_data_out = data_q;
    assign we_out         = we_q;
    assign frame_done_out = done_q;
    assign error_out      = err_q;

endmodule
